// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register data path: FSM encoding,
// default word width and bit-order selectors.
package shift_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_t;

  localparam int SHIFT_WIDTH_DEFAULT = 6;

  localparam bit MSB_FIRST_ORDER = 1'b1;
  localparam bit LSB_FIRST_ORDER = 1'b0;

endpackage

// File: rtl/shift_deser_core.sv
// Bit collector: shift register, bit counter and IDLE/SHIFT FSM. wordDone and
// wordData are combinational so the holding register loads on the last-bit edge.
module shift_deser_core
  import shift_pkg::*;
#(
  parameter int WIDTH     = SHIFT_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = MSB_FIRST_ORDER,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             shiftEnable,
  input  logic             serialIn,
  output logic             wordDone,
  output logic [WIDTH-1:0] wordData,
  output logic [CW-1:0]    bitCount
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  shift_state_t     r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             w_accept;
  logic [WIDTH-1:0] w_next;

  assign w_accept = enable & shiftEnable;

  generate
    if (MSB_FIRST) begin : g_msb
      assign w_next = {r_shift[WIDTH-2:0], serialIn};
    end else begin : g_lsb
      assign w_next = {serialIn, r_shift[WIDTH-1:1]};
    end
  endgenerate

  assign wordDone = w_accept && (r_state == ST_SHIFT) && (r_cnt == LAST);
  assign wordData = w_next;
  assign bitCount = r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (!enable) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      if (wordDone) begin
        // Clear the shifter so the next word never sees stale bits.
        r_state <= ST_IDLE;
        r_shift <= '0;
        r_cnt   <= '0;
      end else begin
        r_state <= ST_SHIFT;
        r_shift <= w_next;
        r_cnt   <= (r_state == ST_IDLE) ? CW'(1) : r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: core bit collector plus a one-word holding
// register with valid/ready handshake and sticky overrun flag.
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int WIDTH     = SHIFT_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = MSB_FIRST_ORDER,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             shiftEnable,
  input  logic             serialIn,
  input  logic             dataReady,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataValid,
  output logic             overrun,
  output logic [CW-1:0]    bitCount
);

  logic             w_done;
  logic [WIDTH-1:0] w_word;

  shift_deser_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .shiftEnable (shiftEnable),
    .serialIn    (serialIn),
    .wordDone    (w_done),
    .wordData    (w_word),
    .bitCount    (bitCount)
  );

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ovr;

  assign dataOut   = r_data;
  assign dataValid = r_valid;
  assign overrun   = r_ovr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_done) begin
        // A consume on the same edge frees the slot for the new word.
        if (!r_valid || dataReady) begin
          r_data  <= w_word;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && dataReady) begin
        r_valid <= 1'b0;
      end
      if (!enable) r_ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench driving one stream into MSB-first and LSB-first instances;
// expected words queued at stimulus time and popped at completion.
module tb_shift_deserializer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       shiftEnable = 1'b0;
  logic       serialIn = 1'b0;
  logic       dataReady = 1'b0;
  logic [5:0] dout_m, dout_l;
  logic       vld_m, vld_l, ovr_m, ovr_l;
  logic [2:0] cnt_m, cnt_l;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [5:0] q_m[$];
  logic [5:0] q_l[$];

  always #5 clk = ~clk;

  shift_deserializer #(.WIDTH(6), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .enable(enable), .shiftEnable(shiftEnable),
    .serialIn(serialIn), .dataReady(dataReady), .dataOut(dout_m),
    .dataValid(vld_m), .overrun(ovr_m), .bitCount(cnt_m));

  shift_deserializer #(.WIDTH(6), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .enable(enable), .shiftEnable(shiftEnable),
    .serialIn(serialIn), .dataReady(dataReady), .dataOut(dout_l),
    .dataValid(vld_l), .overrun(ovr_l), .bitCount(cnt_l));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] rev6(input logic [5:0] w);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = w[5-i];
    return r;
  endfunction

  task automatic send_bit(input logic b, input int gap, input logic rdy);
    repeat (gap) begin
      shiftEnable = 1'b0;
      tick();
      chk("gap_cnt", int'(cnt_m), exp_cnt);
    end
    shiftEnable = 1'b1;
    serialIn    = b;
    dataReady   = rdy;
    tick();
    exp_cnt = (exp_cnt == 5) ? 0 : exp_cnt + 1;
    chk("bit_cnt_m", int'(cnt_m), exp_cnt);
    chk("bit_cnt_l", int'(cnt_l), exp_cnt);
    shiftEnable = 1'b0;
    dataReady   = 1'b0;
  endtask

  // Bits go out w[5] first; MSB-first instance rebuilds w, LSB-first gets rev6(w).
  task automatic send_word(input logic [5:0] w, input int maxgap, input logic rdy_last);
    q_m.push_back(w);
    q_l.push_back(rev6(w));
    for (int i = 5; i >= 0; i--)
      send_bit(w[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0,
               (i == 0) ? rdy_last : 1'b0);
  endtask

  // Pop the queued word; if it was dropped, dataOut must still show the held word.
  task automatic expect_word(input logic acc, input logic [5:0] held_m, input logic [5:0] held_l);
    logic [5:0] em, el;
    em = q_m.pop_front();
    el = q_l.pop_front();
    chk("word_m", int'(dout_m), acc ? int'(em) : int'(held_m));
    chk("word_l", int'(dout_l), acc ? int'(el) : int'(held_l));
    chk("valid_m", int'(vld_m), 1);
  endtask

  task automatic consume();
    dataReady = 1'b1;
    tick();
    dataReady = 1'b0;
    chk("consume_valid_m", int'(vld_m), 0);
    chk("consume_valid_l", int'(vld_l), 0);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_dout", int'(dout_m), 0);
    chk("rst_valid", int'(vld_m), 0);
    chk("rst_ovr", int'(ovr_m), 0);
    chk("rst_cnt", int'(cnt_m), 0);
    #4 reset = 1'b1;
    enable = 1'b1;
    tick();

    // Async reset mid-word with a held word pending
    send_word(6'b101101, 0, 1'b0);
    expect_word(1'b1, 6'd0, 6'd0);
    send_bit(1'b1, 0, 1'b0);
    send_bit(1'b0, 0, 1'b0);
    send_bit(1'b1, 0, 1'b0);
    chk("pre_rst_cnt", int'(cnt_m), 3);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_dout", int'(dout_m), 0);
    chk("async_rst_valid", int'(vld_m), 0);
    chk("async_rst_cnt", int'(cnt_m), 0);
    exp_cnt = 0;
    #3 reset = 1'b1;
    tick();

    // Basic receive: 110001 -> 49 MSB-first, 35 LSB-first
    send_word(6'b110001, 0, 1'b0);
    expect_word(1'b1, 6'd0, 6'd0);
    chk("basic_cnt", int'(cnt_m), 0);
    consume();
    chk("hold_after_consume", int'(dout_m), 49);

    // Gapped bits
    send_word(6'b110001, 3, 1'b0);
    expect_word(1'b1, 6'd0, 6'd0);
    chk("gap_lsb_word", int'(dout_l), 35);

    // Overrun: second word dropped while first unconsumed
    send_word(6'b000111, 0, 1'b0);
    expect_word(1'b0, 6'd49, 6'd35);
    chk("ovr_m", int'(ovr_m), 1);
    chk("ovr_l", int'(ovr_l), 1);
    chk("ovr_cnt", int'(cnt_m), 0);
    enable = 1'b0;
    tick();
    chk("ovr_clr", int'(ovr_m), 0);
    chk("ovr_clr_valid", int'(vld_m), 1);
    // shiftEnable ignored while disabled
    shiftEnable = 1'b1;
    serialIn    = 1'b1;
    tick();
    shiftEnable = 1'b0;
    chk("dis_no_accept", int'(cnt_m), 0);
    chk("dis_valid_held", int'(vld_m), 1);
    enable = 1'b1;

    // Completion on the same edge as consume
    send_word(6'b101010, 0, 1'b1);
    expect_word(1'b1, 6'd0, 6'd0);
    chk("simul_ovr", int'(ovr_m), 0);
    chk("simul_dout", int'(dout_m), 42);
    consume();

    // Flush mid-word
    send_bit(1'b0, 0, 1'b0);
    send_bit(1'b0, 0, 1'b0);
    send_bit(1'b0, 0, 1'b0);
    enable = 1'b0;
    tick();
    exp_cnt = 0;
    chk("flush_cnt", int'(cnt_m), 0);
    enable = 1'b1;
    send_word(6'b111111, 1, 1'b0);
    expect_word(1'b1, 6'd0, 6'd0);
    chk("flush_dout", int'(dout_m), 63);

    // Consume still works with enable low
    enable    = 1'b0;
    dataReady = 1'b1;
    tick();
    dataReady = 1'b0;
    chk("dis_consume", int'(vld_m), 0);
    chk("dis_hold_dout", int'(dout_m), 63);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
- Serial-to-parallel receive end for the ShiftRegister data path: collects bits from a serial stream into WIDTH-bit words and presents each completed word on a parallel output with a valid/ready handshake.
- One-word holding buffer decouples bit collection from the consumer.
- Sits between a serial link (or a ShiftRegister serial output) and word-level logic.

Parameters:
- WIDTH, 6, word width in bits (≥2).
- MSB_FIRST, 1, 1 = first received bit lands in dataOut[WIDTH-1]; 0 = first bit lands in dataOut[0].

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  block enable; 0 flushes the partial word and clears overrun.
- shiftEnable  input  1  serialIn carries a valid bit this cycle.
- serialIn  input  1  serial data bit.
- dataReady  input  1  consumer accepts dataOut this cycle.
- dataOut  output  WIDTH  last completed word (holding register).
- dataValid  output  1  dataOut holds an unconsumed word.
- overrun  output  1  sticky: a completed word was dropped because the holding register was full.
- bitCount  output  clog2(WIDTH)  number of bits collected in the current partial word.

Behaviour:
- Reset (reset=0, async): dataOut=0, dataValid=0, overrun=0, bitCount=0, shift register=0, FSM=IDLE. Takes effect immediately, including mid-word; the partial word is lost.
- Bit accept: shiftEnable=1 and enable=1 at a rising edge.
  - MSB_FIRST=1: shift left, serialIn enters bit 0.
  - MSB_FIRST=0: shift right, serialIn enters bit WIDTH-1.
- FSM (2 states):
  - IDLE: bitCount=0. An accepted bit moves to SHIFT with bitCount=1.
  - SHIFT: each accepted bit increments bitCount.
  - On the accepted bit with bitCount=WIDTH-1, the word completes: bitCount wraps to 0, FSM returns to IDLE.
  - Cycles with shiftEnable=0 hold state; gaps between bits are allowed.
- Completion latency: completed word appears on dataOut with dataValid=1 at the same rising edge that accepts its last bit, so it is visible in the following cycle.
- Handshake:
  - Consume: dataValid=1 and dataReady=1 at an edge clears dataValid, unless a word completes at the same edge.
  - dataOut holds its value after consumption; it is not cleared.
- Boundary conditions:
  - Completion while dataValid=0: load dataOut, set dataValid.
  - Completion while dataValid=1 and dataReady=1 (simultaneous): load the new word, dataValid stays 1, no overrun.
  - Completion while dataValid=1 and dataReady=0: new word dropped, dataOut/dataValid unchanged, overrun set to 1 (sticky), shifter restarts at bitCount=0.
  - enable=0: shift register and bitCount cleared to 0, FSM=IDLE, overrun cleared. dataOut/dataValid are not affected and handshake consumption still operates. shiftEnable is ignored.
  - enable deasserted mid-word: partial word discarded; the next word starts fresh after enable returns to 1.
  - shiftEnable=1 with enable=0: no bit accepted.
- Outputs are registered; no combinational input-to-output paths.

Decomposition:
- Shared package (shift_pkg):
  - FSM state encoding (ST_IDLE, ST_SHIFT).
  - Default WIDTH constant shared with ShiftRegister.
  - Bit-order constants MSB_FIRST_ORDER/LSB_FIRST_ORDER.
- One natural sub-module: shift_deser_core (shift register + bitCount + FSM, emits a one-cycle wordDone pulse and wordData).
- Top level adds the holding register, handshake and overrun logic.

Test Plan:
1. Reset check:
   - Stimulus: reset=0 mid-word with bitCount=3.
   - Response: all outputs 0 immediately (before the next edge). After reset=1, a fresh 6-bit word is received correctly.
2. Basic receive (WIDTH=6, MSB_FIRST=1):
   - Stimulus: enable=1, bits 1,1,0,0,0,1 on consecutive cycles, dataReady=0.
   - Response: after the 6th edge, dataOut=49, dataValid=1, bitCount=0.
   - Stimulus: then dataReady=1 for one cycle.
   - Response: dataValid=0, dataOut stays 49.
3. Gapped bits and LSB-first (MSB_FIRST=0):
   - Stimulus: the same 6 bits with shiftEnable=0 gaps of 0–3 cycles between bits.
   - Response: dataOut=6'b100011 (35); bitCount steps 1..5 only on accepted bits.
4. Overrun:
   - Stimulus: receive 49, hold dataReady=0, receive a second word 6'b000111.
   - Response: dataOut stays 49, dataValid=1, overrun=1.
   - Stimulus: then enable=0 for one cycle.
   - Response: overrun=0, dataValid still 1.
5. Simultaneous completion and consume:
   - Stimulus: dataValid=1 with 49; the last bit of 6'b101010 arrives in the same cycle as dataReady=1.
   - Response: dataOut=42, dataValid=1, overrun=0.
6. Flush mid-word:
   - Stimulus: 3 bits accepted, enable=0 for one cycle, enable=1, then 6 bits of 6'b111111.
   - Response: dataOut=63, no residue from the flushed bits.
